// File: rtl/rdata_arb_mux.sv
// rdata_arb_mux: AXI read-data multiplexer for one master port.
// Routes R beats from NUM_S slaves whose RID master-select field matches
// 'sel'. Arbitration is round-robin and the grant is held for a whole burst,
// so the beats of different bursts are never interleaved. An optional output
// register stage can be placed between the arbiter and the master.
`timescale 1ns/1ps

module rdata_arb_mux #(
  parameter int NUM_S   = 4,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 2,
  parameter int OUT_REG = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_S*ID_W-1:0]    rid_s,
  input  logic [NUM_S*DATA_W-1:0]  rdata_s,
  input  logic [NUM_S-1:0]         rlast_s,
  input  logic [NUM_S*2-1:0]       rresp_s,
  input  logic [NUM_S-1:0]         rvalid_s,
  output logic [NUM_S-1:0]         rready_s,
  output logic [ID_W-1:0]          rid_m,
  output logic [DATA_W-1:0]        rdata_m,
  output logic                     rlast_m,
  output logic [1:0]               rresp_m,
  output logic                     rvalid_m,
  input  logic                     rready_m,
  output logic [NUM_S-1:0]         grant,
  output logic                     burst_active
);

  localparam int IDX_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic [NUM_S-1:0] req;
  logic             hi_found, lo_found, pick_found;
  logic [IDX_W-1:0] hi_idx, lo_idx, pick_idx;

  logic             cur_active;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_valid;
  logic             cur_last;
  logic [ID_W-1:0]  cur_rid;
  logic [DATA_W-1:0] cur_data;
  logic [1:0]       cur_resp;
  logic [NUM_S-1:0] sel_mask;

  logic             slave_ready;
  logic             handshake;

  // Index of the slave after idx, wrapping from the last slave back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_S - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

  // A slave requests only when it is valid and its RID targets this master.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_S; i++) begin
      req[i] = rvalid_s[i] && (rid_s[i*ID_W + ID_W - 1 -: SEL_W] == sel);
    end
  end

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    pick_found = lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // The routed slave is the frozen grant while locked, else the fresh pick.
  always_comb begin
    if (state_q == ST_LOCK) begin
      cur_active = 1'b1;
      cur_idx    = gnt_idx_q;
    end else begin
      cur_active = pick_found;
      cur_idx    = pick_idx;
    end
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_rid   = '0;
    cur_data  = '0;
    cur_resp  = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (cur_active && (cur_idx == IDX_W'(i))) begin
        sel_mask[i] = 1'b1;
        cur_valid   = rvalid_s[i];
        cur_last    = rlast_s[i];
        cur_rid     = rid_s[i*ID_W +: ID_W];
        cur_data    = rdata_s[i*DATA_W +: DATA_W];
        cur_resp    = rresp_s[i*2 +: 2];
      end
    end
    handshake = cur_valid && slave_ready && !areset;
  end

  assign grant        = areset ? '0 : sel_mask;
  assign rready_s     = areset ? '0 : (sel_mask & {NUM_S{slave_ready}});
  assign burst_active = (state_q == ST_LOCK);

  // Arbiter next state: lock on a non-last first beat, release on the last beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (cur_last) begin
            rr_ptr_d = next_idx(cur_idx);
          end else begin
            state_d   = ST_LOCK;
            gnt_idx_d = cur_idx;
          end
        end
      end
      ST_LOCK: begin
        if (handshake && cur_last) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = next_idx(gnt_idx_q);
          gnt_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_idx_d = '0;
      end
    endcase
  end

  // Arbiter state register; reset aborts any burst and restarts from slave 0.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic              out_valid_q;
      logic [ID_W-1:0]   out_rid_q;
      logic [DATA_W-1:0] out_data_q;
      logic              out_last_q;
      logic [1:0]        out_resp_q;

      // The slot can take a new beat when empty or when it drains this cycle.
      assign slave_ready = !out_valid_q || rready_m;

      // One-entry skid: capture on slave handshake, hold until master accepts.
      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          out_valid_q <= 1'b0;
          out_rid_q   <= '0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
          out_resp_q  <= '0;
        end else if (handshake) begin
          out_valid_q <= 1'b1;
          out_rid_q   <= cur_rid;
          out_data_q  <= cur_data;
          out_last_q  <= cur_last;
          out_resp_q  <= cur_resp;
        end else if (rready_m) begin
          out_valid_q <= 1'b0;
        end
      end

      assign rvalid_m = out_valid_q;
      assign rid_m    = out_rid_q;
      assign rdata_m  = out_data_q;
      assign rlast_m  = out_last_q;
      assign rresp_m  = out_resp_q;
    end else begin : g_comb
      logic pass_valid;

      assign slave_ready = rready_m;
      assign pass_valid  = cur_valid && !areset;

      assign rvalid_m = pass_valid;
      assign rid_m    = pass_valid ? cur_rid  : '0;
      assign rdata_m  = pass_valid ? cur_data : '0;
      assign rlast_m  = pass_valid && cur_last;
      assign rresp_m  = pass_valid ? cur_resp : '0;
    end
  endgenerate

endmodule

// File: doc/rdata_arb_mux.md
Name: rdata_arb_mux

Overview:
- Parametrised AXI read-data channel multiplexer. It routes R beats from NUM_S slaves to one master port.
- A slave is eligible only when the master-select field of its RID (the top SEL_W bits) equals sel.
- Eligible slaves are picked by round-robin arbitration. The grant is held for a whole burst, until the RLAST beat is accepted.
- An optional output register stage breaks the timing path. The block sits in the interconnect, one instance per master.

Parameters:
- NUM_S, 4, number of slave ports (2..16).
- ID_W, 4, RID width.
- DATA_W, 32, RDATA width.
- SEL_W, 2, width of the master-select field, taken from rid[ID_W-1 -: SEL_W].
- OUT_REG, 1, 1 = registered master outputs (1-cycle latency); 0 = combinational pass-through.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  master-select value for this master port.
- rid_s  in  NUM_S*ID_W  slave RIDs, flattened; slave i occupies [i*ID_W +: ID_W].
- rdata_s  in  NUM_S*DATA_W  slave RDATA, flattened.
- rlast_s  in  NUM_S  slave RLAST.
- rresp_s  in  NUM_S*2  slave RRESP, flattened.
- rvalid_s  in  NUM_S  slave RVALID.
- rready_s  out  NUM_S  slave RREADY.
- rid_m  out  ID_W  master RID.
- rdata_m  out  DATA_W  master RDATA.
- rlast_m  out  1  master RLAST.
- rresp_m  out  2  master RRESP.
- rvalid_m  out  1  master RVALID.
- rready_m  in  1  master RREADY.
- grant  out  NUM_S  one-hot current grant; all zeros when idle.
- burst_active  out  1  high while a burst is locked.

Behaviour:
- Eligibility: req[i] = rvalid_s[i] & (rid_s[i][ID_W-1 -: SEL_W] == sel).
- State machine, two states:
  - IDLE: when any req bit is set, grant the first requester at or after rr_ptr, wrapping modulo NUM_S. Register the grant and move to LOCK in the same cycle the first beat is transferred.
  - LOCK: the grant is frozen. sel changes and other requests are ignored.
  - Exit from LOCK: on the rlast beat handshake from the granted slave (rvalid & rready & rlast), clear the grant, set rr_ptr = granted index + 1 (wrapping NUM_S-1 -> 0), and return to IDLE.
- Single-beat burst: when the first beat has rlast=1, the block grants and releases in the same transfer. It never enters LOCK, and rr_ptr still advances.
- rready_s[i] is high only for the granted or selected slave, and 0 for every other slave.
- OUT_REG=0:
  - Master outputs are driven combinationally from the selected slave; rready_s[g] = rready_m.
  - When nothing is selected: rvalid_m=0, rlast_m=0, rid_m/rdata_m/rresp_m=0.
- OUT_REG=1:
  - One-entry pipeline register: rready_s[g] = !rvalid_m | rready_m, giving full throughput of 1 beat/cycle.
  - Each captured beat appears on the master one cycle later.
  - Held data must stay stable while rvalid_m=1 & rready_m=0 (AXI rule).
  - The lock is released on the slave-side handshake of the rlast beat; the register still holds it. The next arbitration may capture a new beat in the same cycle the register drains.
- Backpressure: rvalid_m is never dropped without a handshake, and a beat is never duplicated or lost.
- Reset:
  - While areset=1: all outputs are 0 (rvalid_m, rlast_m, rid_m, rdata_m, rresp_m, rready_s, grant, burst_active), state=IDLE, rr_ptr=0.
  - Asserting reset mid-burst aborts the burst immediately. There is no pending state after release.
- The first arbitration after reset starts from slave 0.
- Slaves whose RID select field does not match sel are never granted and never see rready.

Test Plan:
- Reset then single source: OUT_REG=1, sel=2'b01, slave 2 sends a 4-beat burst with rid=4'b0110, data 0xA0..0xA3, rready_m=1 → master sees 4 beats on consecutive cycles starting 1 cycle after the first slave beat; rlast_m only on 0xA3; rready_s=0b0100 during the burst.
- Contention round-robin: slaves 0,1,3 all valid with matching IDs, 2-beat bursts each → grant order 0,1,3 with no interleaving inside a burst; a second round with all valid again grants 0 first (pointer wraps 3 → 0).
- Lock vs sel change: sel switches 01 → 10 mid-burst on slave 1 → burst completes on slave 1; afterwards only slaves with RID[3:2]=10 are granted.
- Backpressure: rready_m toggles 1,0,0,1 during a 3-beat burst → rdata_m/rid_m stay stable while stalled; exactly 3 beats delivered in order; no slave beat lost.
- Mismatched IDs: rvalid_s=4'b1111 with no RID matching sel → rvalid_m=0, rready_s=0, grant=0 indefinitely.
- Reset mid-burst: areset asserted on beat 2 of 4 → all outputs 0 in the same cycle (asynchronous); after release with slave 3 valid, the grant goes to slave 3 and rr_ptr starts from 0.
